// File: rtl/mips_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - MIPS load/store opcodes (INSTR_M[31:26])
//   - exception codes written to EXP_OUT_M
//   - LSU FSM state encoding and access-size enum
//   - opcode decode helpers for access size and load signedness
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // Unrecognised opcodes that still carry a memory flag fall back to word.
  function automatic mem_size_e op_size(input logic [5:0] op);
    mem_size_e sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      OP_LW, OP_SW:         sz = SZ_WORD;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// load_extend: picks the addressed byte/half out of a little-endian read
// word and sign- or zero-extends it to 32 bits. Purely combinational.
// Ports:
//   i_rdata  [31:0]  word returned by the bus
//   i_lane   [1:0]   byte offset of the access (addr[1:0])
//   i_size           access size (byte/half/word)
//   i_signed         1 = sign-extend, 0 = zero-extend
//   o_data   [31:0]  extended load result
module load_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  mem_size_e   i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
  // Halves are always aligned, so only lane bit 1 chooses the half.
  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit. Decodes size/sign from the
// opcode, checks alignment, runs one req/ack bus transaction per aligned
// access while holding the pipeline with STALL_M, and returns extended load
// data plus the merged exception code.
// Optional feature: define MEM_TIMEOUT_EN to abort a request that sees no
// ack within TIMEOUT_CYCLES REQ cycles (reported as DBE, code 7).
// Ports:
//   clk, reset (async, active-low)
//   INSTR_M, ALU_OUT_M, FRead_Data_2_M, MEM_WRITE_ENABLED_M, MEM_TO_REG_M,
//   EXP_M                         : E/M pipeline-register inputs
//   bus_req/we/addr/be/wdata      : bus initiator outputs
//   bus_ack, bus_rdata            : bus responder inputs
//   STALL_M, LOAD_DATA_M, EXP_OUT_M : to pipeline control and M/W register
module mem_stage_lsu
  import mips_mem_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INSTR_M,
  input  logic [31:0] ALU_OUT_M,
  input  logic [31:0] FRead_Data_2_M,
  input  logic        MEM_WRITE_ENABLED_M,
  input  logic [1:0]  MEM_TO_REG_M,
  input  logic [4:0]  EXP_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        STALL_M,
  output logic [31:0] LOAD_DATA_M,
  output logic [4:0]  EXP_OUT_M
);

  // ---------------- decode ----------------
  logic [5:0]  w_op;
  logic [1:0]  w_lane;
  logic        w_is_store;
  logic        w_is_load;
  logic        w_mem_op;
  mem_size_e   w_size;
  logic        w_signed;
  logic        w_misaligned;
  logic        w_start;
  logic [3:0]  w_be_next;
  logic [31:0] w_wdata_next;
  logic        w_unused_instr;

  assign w_op       = INSTR_M[31:26];
  assign w_lane     = ALU_OUT_M[1:0];
  // A store flag wins if both flags were ever set together.
  assign w_is_store = MEM_WRITE_ENABLED_M;
  assign w_is_load  = (MEM_TO_REG_M == 2'b01) & ~MEM_WRITE_ENABLED_M;
  assign w_mem_op   = w_is_store | w_is_load;
  assign w_size     = op_size(w_op);
  assign w_signed   = op_is_signed(w_op);
  assign w_unused_instr = ^INSTR_M[25:0];

  always_comb begin
    w_misaligned = 1'b0;
    case (w_size)
      SZ_HALF: w_misaligned = w_lane[0];
      SZ_WORD: w_misaligned = |w_lane;
      default: w_misaligned = 1'b0;
    endcase
  end

  // ---------------- FSM ----------------
  lsu_state_e r_state;
  lsu_state_e w_state_next;
  logic       w_req;
  logic       w_stall;
  logic       w_timeout_hit;
  logic       w_dbe;

  // Incoming exceptions and alignment faults suppress the access entirely.
  assign w_start = (r_state == ST_IDLE) & w_mem_op & (EXP_M == EXC_NONE) & ~w_misaligned;

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_stall      = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (bus_ack || w_timeout_hit) begin
          w_state_next = ST_DONE;
        end
      end
      // Pipeline advances at the end of DONE, so returning to IDLE cannot
      // re-issue the same instruction.
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- request attributes ----------------
  always_comb begin
    w_be_next = 4'b1111;
    if (w_is_store) begin
      case (w_size)
        SZ_BYTE: w_be_next = 4'b0001 << w_lane;
        SZ_HALF: w_be_next = 4'b0011 << w_lane;
        default: w_be_next = 4'b1111;
      endcase
    end
  end

  // Store data replicated across lanes so the byte enables alone select it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wdata_next[8*gi +: 8] =
        (w_size == SZ_BYTE) ? FRead_Data_2_M[7:0] :
        (w_size == SZ_HALF) ? FRead_Data_2_M[8*(gi%2) +: 8] :
                              FRead_Data_2_M[8*gi +: 8];
    end
  endgenerate

  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  mem_size_e   r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_load_data;
  logic [31:0] w_load_ext;
  logic        w_capture;

  assign w_capture = (r_state == ST_REQ) & bus_ack & ~r_we;

  load_extend u_load_extend (
    .i_rdata  (bus_rdata),
    .i_lane   (r_lane),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_load_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= 32'd0;
      r_we        <= 1'b0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_size      <= SZ_WORD;
      r_signed    <= 1'b0;
      r_lane      <= 2'd0;
      r_load_data <= 32'd0;
    end else begin
      r_state <= w_state_next;
      // Bus attributes are frozen on entry to REQ and held until the next access.
      if (w_start) begin
        r_addr   <= {ALU_OUT_M[31:2], 2'b00};
        r_we     <= w_is_store;
        r_be     <= w_be_next;
        r_wdata  <= w_wdata_next;
        r_size   <= w_size;
        r_signed <= w_signed;
        r_lane   <= w_lane;
      end
      if (w_capture) begin
        r_load_data <= w_load_ext;
      end
    end
  end

  // ---------------- optional request timeout ----------------
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_dbe;

  // Abort on the last allowed REQ cycle unless the ack arrives in it.
  assign w_timeout_hit = (r_state == ST_REQ) & ~bus_ack &
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_dbe = r_dbe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_dbe <= 1'b0;
    end else begin
      if (r_state != w_state_next) begin
        r_cnt <= '0;
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // High only during the DONE cycle that follows an abort.
      r_dbe <= w_timeout_hit;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign w_dbe         = 1'b0;
`endif

  // ---------------- outputs ----------------
  always_comb begin
    EXP_OUT_M = EXC_NONE;
    if (EXP_M != EXC_NONE) begin
      EXP_OUT_M = EXP_M;
    end else if (w_mem_op && w_misaligned) begin
      EXP_OUT_M = w_is_store ? EXC_ADES : EXC_ADEL;
    end else if (w_dbe) begin
      EXP_OUT_M = EXC_DBE;
    end
  end

  assign bus_req     = w_req;
  assign bus_we      = r_we;
  assign bus_addr    = r_addr;
  assign bus_be      = r_be;
  assign bus_wdata   = r_wdata;
  assign STALL_M     = w_stall;
  assign LOAD_DATA_M = r_load_data;

endmodule
